// File: rtl/psg_channel_mixer.sv
// psg_channel_mixer
//
// Mixes the three channels of an AY-3-8910 style PSG into one sample.
// On a sample strobe the tone/noise bits, R7 mixer control, the three
// amplitude registers and the envelope level are snapshotted. The three
// channels are then gated, mapped through a logarithmic DAC table and
// summed one per cycle. The result is presented as a registered sample
// with a one-cycle valid pulse, four edges after the strobe.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       sample strobe; starts a mix pass when idle
//   tone_a/b/c   tone generator square outputs
//   noise        shared noise generator bit
//   mixer_ctrl   R7: [2:0] tone disable A/B/C, [5:3] noise disable A/B/C
//   amp_a/b/c    R8-R10: bit4 selects envelope, bits[3:0] fixed level
//   envelope     current envelope level
//   sample       registered mono mix (A+B+C)
//   sample_valid one-cycle pulse when sample updates
//   overrun      one-cycle pulse when a strobe arrives during a pass
//
// Optional build macro PSG_MIXER_STEREO_EN adds sample_left (A + B/2)
// and sample_right (C + B/2), updated together with sample.

module psg_channel_mixer #(
    parameter int LEVEL_BITS = 8,
    parameter int OUT_BITS   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                tone_a,
    input  logic                tone_b,
    input  logic                tone_c,
    input  logic                noise,
    input  logic [5:0]          mixer_ctrl,
    input  logic [4:0]          amp_a,
    input  logic [4:0]          amp_b,
    input  logic [4:0]          amp_c,
    input  logic [3:0]          envelope,
    output logic [OUT_BITS-1:0] sample,
    output logic                sample_valid,
    output logic                overrun
`ifdef PSG_MIXER_STEREO_EN
    ,
    output logic [OUT_BITS-1:0] sample_left,
    output logic [OUT_BITS-1:0] sample_right
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_A,
        ST_CH_B,
        ST_CH_C,
        ST_OUT
    } state_t;

    // The 8-bit reference table is rescaled to LEVEL_BITS with rounding,
    // round(x/255) computed as floor((2x + 255) / 510).
    function automatic logic [16*LEVEL_BITS-1:0] build_dac();
        logic [16*LEVEL_BITS-1:0] table_bits;
        logic [LEVEL_BITS-1:0]    entry;
        longint                   base;
        longint                   scaled;
        table_bits = '0;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       base = 0;
                1:       base = 2;
                2:       base = 3;
                3:       base = 4;
                4:       base = 6;
                5:       base = 8;
                6:       base = 11;
                7:       base = 16;
                8:       base = 23;
                9:       base = 32;
                10:      base = 45;
                11:      base = 64;
                12:      base = 90;
                13:      base = 128;
                14:      base = 181;
                default: base = 255;
            endcase
            scaled = (base * ((longint'(1) << LEVEL_BITS) - 1) * 2 + 255) / 510;
            entry  = LEVEL_BITS'(scaled);
            table_bits[i*LEVEL_BITS +: LEVEL_BITS] = entry;
        end
        return table_bits;
    endfunction

    localparam logic [16*LEVEL_BITS-1:0] DAC_TABLE = build_dac();

    state_t              state_q, state_d;
    logic [2:0]          tone_q, tone_d;
    logic                noise_q, noise_d;
    logic [5:0]          mixer_q, mixer_d;
    logic [4:0]          amp_a_q, amp_a_d;
    logic [4:0]          amp_b_q, amp_b_d;
    logic [4:0]          amp_c_q, amp_c_d;
    logic [3:0]          env_q, env_d;
    logic [OUT_BITS-1:0] acc_q, acc_d;
    logic [OUT_BITS-1:0] sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                overrun_q, overrun_d;
`ifdef PSG_MIXER_STEREO_EN
    logic [OUT_BITS-1:0] acc_l_q, acc_l_d;
    logic [OUT_BITS-1:0] acc_r_q, acc_r_d;
    logic [OUT_BITS-1:0] sample_l_q, sample_l_d;
    logic [OUT_BITS-1:0] sample_r_q, sample_r_d;
`endif

    logic                  ch_tone;
    logic                  ch_tone_dis;
    logic                  ch_noise_dis;
    logic [4:0]            ch_amp;
    logic                  ch_active;
    logic [3:0]            ch_level;
    logic [LEVEL_BITS-1:0] ch_contrib;
    logic [OUT_BITS-1:0]   contrib_ext;

    // Select the snapshot of the channel being accumulated this cycle.
    // IDLE/OUT fall back to channel A; the result is ignored there.
    always_comb begin
        ch_tone      = tone_q[0];
        ch_tone_dis  = mixer_q[0];
        ch_noise_dis = mixer_q[3];
        ch_amp       = amp_a_q;
        case (state_q)
            ST_CH_B: begin
                ch_tone      = tone_q[1];
                ch_tone_dis  = mixer_q[1];
                ch_noise_dis = mixer_q[4];
                ch_amp       = amp_b_q;
            end
            ST_CH_C: begin
                ch_tone      = tone_q[2];
                ch_tone_dis  = mixer_q[2];
                ch_noise_dis = mixer_q[5];
                ch_amp       = amp_c_q;
            end
            default: ;
        endcase
        // A disabled source counts as permanently high, so a channel with
        // both sources disabled outputs its DC level.
        ch_active   = (ch_tone | ch_tone_dis) & (noise_q | ch_noise_dis);
        ch_level    = ch_amp[4] ? env_q : ch_amp[3:0];
        ch_contrib  = ch_active ? DAC_TABLE[32'(ch_level)*LEVEL_BITS +: LEVEL_BITS]
                                : '0;
        contrib_ext = {{(OUT_BITS-LEVEL_BITS){1'b0}}, ch_contrib};
    end

    // Next-state and datapath: snapshot on an accepted strobe, add one
    // channel per state, publish in OUT. Strobes outside IDLE (OUT
    // included) are dropped and flagged as overrun.
    always_comb begin
        state_d        = state_q;
        tone_d         = tone_q;
        noise_d        = noise_q;
        mixer_d        = mixer_q;
        amp_a_d        = amp_a_q;
        amp_b_d        = amp_b_q;
        amp_c_d        = amp_c_q;
        env_d          = env_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        overrun_d      = enable && (state_q != ST_IDLE);
`ifdef PSG_MIXER_STEREO_EN
        acc_l_d        = acc_l_q;
        acc_r_d        = acc_r_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    tone_d  = {tone_c, tone_b, tone_a};
                    noise_d = noise;
                    mixer_d = mixer_ctrl;
                    amp_a_d = amp_a;
                    amp_b_d = amp_b;
                    amp_c_d = amp_c;
                    env_d   = envelope;
                    acc_d   = '0;
`ifdef PSG_MIXER_STEREO_EN
                    acc_l_d = '0;
                    acc_r_d = '0;
`endif
                    state_d = ST_CH_A;
                end
            end
            ST_CH_A: begin
                acc_d   = acc_q + contrib_ext;
`ifdef PSG_MIXER_STEREO_EN
                acc_l_d = acc_l_q + contrib_ext;
`endif
                state_d = ST_CH_B;
            end
            ST_CH_B: begin
                acc_d   = acc_q + contrib_ext;
`ifdef PSG_MIXER_STEREO_EN
                // Centre channel is split between both sides, truncated.
                acc_l_d = acc_l_q + (contrib_ext >> 1);
                acc_r_d = acc_r_q + (contrib_ext >> 1);
`endif
                state_d = ST_CH_C;
            end
            ST_CH_C: begin
                acc_d   = acc_q + contrib_ext;
`ifdef PSG_MIXER_STEREO_EN
                acc_r_d = acc_r_q + contrib_ext;
`endif
                state_d = ST_OUT;
            end
            ST_OUT: begin
                sample_d       = acc_q;
                sample_valid_d = 1'b1;
`ifdef PSG_MIXER_STEREO_EN
                sample_l_d     = acc_l_q;
                sample_r_d     = acc_r_q;
`endif
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tone_q         <= '0;
            noise_q        <= 1'b0;
            mixer_q        <= '0;
            amp_a_q        <= '0;
            amp_b_q        <= '0;
            amp_c_q        <= '0;
            env_q          <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef PSG_MIXER_STEREO_EN
            acc_l_q        <= '0;
            acc_r_q        <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            tone_q         <= tone_d;
            noise_q        <= noise_d;
            mixer_q        <= mixer_d;
            amp_a_q        <= amp_a_d;
            amp_b_q        <= amp_b_d;
            amp_c_q        <= amp_c_d;
            env_q          <= env_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
`ifdef PSG_MIXER_STEREO_EN
            acc_l_q        <= acc_l_d;
            acc_r_q        <= acc_r_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
`endif
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
`ifdef PSG_MIXER_STEREO_EN
    assign sample_left  = sample_l_q;
    assign sample_right = sample_r_q;
`endif

endmodule
